// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register bank write port, with a
// pending-load scoreboard that blocks WAW writes and flags decode hazards.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 8,
  parameter int AW   = 3
) (
  input  logic               clkg,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_v,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_dat,
  output logic [NREQ-1:0]    req_rdy,
  input  logic               lock_v,
  input  logic [AW-1:0]      lock_rd,
  output logic               lock_ok,
  input  logic [AW-1:0]      rs_i,
  input  logic [AW-1:0]      rs2_i,
  output logic               haz_rs,
  output logic               haz_rs2,
  output logic               wb_we,
  output logic [AW-1:0]      wb_rd,
  output logic [DW-1:0]      wb_dat,
  output logic [2**AW-1:0]   pend_o
);

  localparam int NR = 2**AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NR-1:0]   pend_reg, pend_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   gnt_rd;
  logic [DW-1:0]   gnt_dat;
  logic            load_clr;

  // The load unit is never held off: it is the one that retires the pending entry.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
      if (gi == 1) begin : g_load
        assign elig[gi] = req_v[gi];
      end else begin : g_other
        assign elig[gi] = req_v[gi] & ~pend_reg[req_rd[gi*AW +: AW]];
      end
    end
  endgenerate

  always_comb begin
    int s;
    s        = 0;
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_rd   = '0;
    gnt_dat  = '0;
    load_clr = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr_reg) + k;
      if (s >= NREQ) s = s - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_any && (i == s) && elig[i]) begin
          gnt_any  = 1'b1;
          gnt[i]   = 1'b1;
          gnt_idx  = PW'(i);
          gnt_rd   = req_rd[i*AW +: AW];
          gnt_dat  = req_dat[i*DW +: DW];
          load_clr = (i == 1);
        end
      end
    end
  end

  assign ptr_next = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
  assign req_rdy  = gnt;
  assign lock_ok  = lock_v & (lock_rd != '0) & ~pend_reg[lock_rd];
  assign haz_rs   = pend_reg[rs_i] & (rs_i != '0);
  assign haz_rs2  = pend_reg[rs2_i] & (rs2_i != '0);
  assign pend_o   = pend_reg;

  // Set is applied after clear so a back-to-back load to the same register stays pending.
  always_comb begin
    pend_next = pend_reg;
    if (load_clr) pend_next[gnt_rd] = 1'b0;
    if (lock_ok)  pend_next[lock_rd] = 1'b1;
  end

  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_dat   <= '0;
      pend_reg <= '0;
      ptr_reg  <= '0;
    end else begin
      wb_we    <= gnt_any & (gnt_rd != '0);
      pend_reg <= pend_next;
      if (gnt_any) begin
        wb_rd   <= gnt_rd;
        wb_dat  <= gnt_dat;
        ptr_reg <= ptr_next;
      end
    end
  end

endmodule
